edac_encoder: RTL and testbench



---
 rtl/edac_encoder_if.sv | 24 ++
 rtl/edac_encoder.sv | 66 ++++++
 tb/tb_edac_encoder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/edac_encoder_if.sv
// rtl/edac_encoder_if.sv - data/codeword bundle between the I/O core and the EDAC encoder
interface edac_encoder_if;
    logic [31:0] Din;
    logic [31:0] LUT_IN;
    logic [7:0]  CRC_POLY;
    logic        en;
    logic [31:0] Dout;

    modport master (
        output Din,
        output LUT_IN,
        output CRC_POLY,
        output en,
        input  Dout
    );

    modport slave (
        input  Din,
        input  LUT_IN,
        input  CRC_POLY,
        input  en,
        output Dout
    );
endinterface

// File: rtl/edac_encoder.sv
// rtl/edac_encoder.sv - registered SECDED Hamming(13,8) + programmable CRC-8 encoder with LUT bypass
module edac_encoder (
    input  logic          clk,
    input  logic          rst_n,
    edac_encoder_if.slave bus
);
    logic [7:0]  d;
    logic [12:0] ham;
    logic [7:0]  crc;
    logic [31:0] computed;
    logic [7:0]  lut_data;
    logic        bypass;
    logic [31:0] next_word;
    logic [31:0] dout_q;
    logic        unused_din_hi;

    assign d             = bus.Din[7:0];
    assign unused_din_hi = ^bus.Din[31:8];

    // Data sits at 1-indexed positions 3,5,6,7,9,10,11,12; parity at 1,2,4,8.
    always_comb begin
        ham      = '0;
        ham[2]   = d[0];
        ham[4]   = d[1];
        ham[5]   = d[2];
        ham[6]   = d[3];
        ham[8]   = d[4];
        ham[9]   = d[5];
        ham[10]  = d[6];
        ham[11]  = d[7];
        ham[0]   = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        ham[1]   = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        ham[3]   = d[1] ^ d[2] ^ d[3] ^ d[7];
        ham[7]   = d[4] ^ d[5] ^ d[6] ^ d[7];
        ham[12]  = ^ham[11:0];
    end

    // MSB-first CRC-8, zero init, fully unrolled so it fits in one cycle.
    always_comb begin
        crc = d;
        for (int i = 0; i < 8; i++) begin
            if (crc[7]) begin
                crc = {crc[6:0], 1'b0} ^ bus.CRC_POLY;
            end else begin
                crc = {crc[6:0], 1'b0};
            end
        end
    end

    assign computed = {crc, 11'b0, ham};

    assign lut_data = {bus.LUT_IN[11], bus.LUT_IN[10], bus.LUT_IN[9], bus.LUT_IN[8],
                       bus.LUT_IN[6],  bus.LUT_IN[5],  bus.LUT_IN[4], bus.LUT_IN[2]};
    assign bypass    = (lut_data == d);
    assign next_word = bypass ? bus.LUT_IN : computed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= 32'h0;
        end else if (bus.en) begin
            dout_q <= next_word;
        end
    end

    assign bus.Dout = dout_q;
endmodule

// File: tb/tb_edac_encoder.sv
// tb/tb_edac_encoder.sv - directed and sweep checks for edac_encoder
module tb_edac_encoder;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    edac_encoder_if bus ();

    edac_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference encoder built from position arithmetic rather than fixed XOR lists.
    function automatic logic [12:0] model_ham(input logic [7:0] data);
        logic [12:0] w;
        int          k;
        int          dpos[8];
        dpos = '{3, 5, 6, 7, 9, 10, 11, 12};
        w = '0;
        for (k = 0; k < 8; k++) w[dpos[k]-1] = data[k];
        for (int p = 1; p <= 8; p = p * 2) begin
            logic par;
            par = 1'b0;
            for (int pos = 1; pos <= 12; pos++)
                if ((pos & p) != 0 && pos != p) par ^= w[pos-1];
            w[p-1] = par;
        end
        w[12] = ^w[11:0];
        return w;
    endfunction

    function automatic logic [7:0] model_crc(input logic [7:0] data, input logic [7:0] poly);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            logic fb;
            fb = c[7] ^ data[i];
            c  = {c[6:0], 1'b0};
            if (fb) c ^= poly;
        end
        return c;
    endfunction

    function automatic logic [3:0] syndrome(input logic [12:0] w);
        logic [3:0] s;
        s = 4'd0;
        for (int pos = 1; pos <= 12; pos++)
            if (w[pos-1]) s ^= pos[3:0];
        return s;
    endfunction

    function automatic logic [12:0] correct(input logic [12:0] w);
        logic [12:0] r;
        logic [3:0]  s;
        r = w;
        s = syndrome(w);
        if (^w) begin
            if (s == 4'd0) r[12] = ~r[12];
            else           r[s-1] = ~r[s-1];
        end
        return r;
    endfunction

    task automatic apply(input logic [7:0] din, input logic [31:0] lut, input logic [7:0] poly);
        @(negedge clk);
        bus.Din      = {24'hA5A5A5, din};
        bus.LUT_IN   = lut;
        bus.CRC_POLY = poly;
        bus.en       = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  polys[2];
        logic [12:0] cw;
        int          bad;
        checks       = 0;
        failures     = 0;
        polys        = '{8'h97, 8'h07};

        rst_n        = 1'b0;
        bus.en       = 1'b1;
        bus.Din      = 32'h0000_000F;
        bus.LUT_IN   = 32'h0;
        bus.CRC_POLY = 8'h97;
        #1;
        check("reset_async", bus.Dout, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", bus.Dout, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        apply(8'h0F, 32'h0, 8'h97);
        check("enc_0f", bus.Dout, 32'h9600_107F);
        apply(8'h10, 32'h0, 8'h97);
        check("enc_10", bus.Dout, 32'hBA00_1181);

        @(negedge clk);
        bus.en  = 1'b0;
        bus.Din = 32'h0000_0011;
        repeat (2) @(posedge clk);
        #1;
        check("en_hold", bus.Dout, 32'hBA00_1181);

        apply(8'h00, 32'h0, 8'h97);
        check("enc_00", bus.Dout, 32'h0);

        apply(8'h0F, 32'hDEAD_0074, 8'h97);
        check("bypass_74", bus.Dout, 32'hDEAD_0074);
        apply(8'h0F, 32'hDEAD_0075, 8'h97);
        check("bypass_75", bus.Dout, 32'hDEAD_0075);
        apply(8'h0F, 32'h0, 8'h97);
        check("bypass_off", bus.Dout, 32'h9600_107F);

        // Reset landing between edges must clear Dout at once and drop the pending capture.
        @(negedge clk);
        bus.Din = 32'h0000_0010;
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid", bus.Dout, 32'h0);
        @(posedge clk);
        #1;
        check("reset_mid_edge", bus.Dout, 32'h0);
        @(negedge clk);
        bus.en = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_en0", bus.Dout, 32'h0);
        apply(8'h10, 32'h0, 8'h97);
        check("post_reset_cap", bus.Dout, 32'hBA00_1181);

        for (int pi = 0; pi < 2; pi++) begin
            for (int v = 0; v < 256; v++) begin
                logic [7:0] dv;
                dv = v[7:0];
                // Bit 2 of the LUT data field is forced to disagree, keeping bypass off.
                apply(dv, {29'b0, ~dv[0], 2'b0}, polys[pi]);
                check("sweep_word", bus.Dout,
                      {model_crc(dv, polys[pi]), 11'b0, model_ham(dv)});
                check("sweep_crc", {24'h0, bus.Dout[31:24]}, {24'h0, model_crc(dv, polys[pi])});
                cw = bus.Dout[12:0];
                check("sweep_syndrome", {28'h0, syndrome(cw)}, 32'h0);
                check("sweep_parity", {31'h0, ^cw}, 32'h0);
                bad = 0;
                for (int k = 0; k < 13; k++) begin
                    logic [12:0] flipped;
                    flipped = cw ^ (13'd1 << k);
                    if (correct(flipped) !== cw) bad++;
                end
                check("sweep_correct", bad, 32'h0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
